apb4_mst: RTL and testbench
===========================

Name: apb4_mst

Overview:
- APB4 initiator (requester side) for the peripheral family's APB4 responders (wdg, timers, etc.).
- Converts a valid/ready request channel and a valid/ready response channel into single APB4 SETUP/ACCESS transfers.
- Used by on-chip engines (DMA-lite, boot sequencer, autonomous watchdog feeder) to program APB4 peripherals without a CPU.

Parameters:
- ADDR_WIDTH, 32, APB4 address width.
- DATA_WIDTH, 32, APB4 data width; must be 8, 16 or 32.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles with pready low; used only with APB4_MST_TIMEOUT_EN.

Ports:
- clk_i  in  1  single clock; APB4 pclk is this clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&&ready.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_write_i  in  1  1=write, 0=read.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_wstrb_i  in  DATA_WIDTH/8  write byte strobes.
- req_prot_i  in  3  pprot value.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&&ready.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err_o  out  1  pslverr or timeout.
- psel_o, penable_o, pwrite_o  out  1 each  APB4 controls.
- paddr_o  out  ADDR_WIDTH.
- pwdata_o  out  DATA_WIDTH.
- pstrb_o  out  DATA_WIDTH/8.
- pprot_o  out  3.
- prdata_i  in  DATA_WIDTH.
- pready_i  in  1.
- pslverr_i  in  1.

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - State goes to IDLE.
  - All outputs 0, except req_ready_o, which is 1 in IDLE.
  - Any in-flight transfer is abandoned and no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, register addr/write/wdata/prot/strb and go to SETUP.
  - Strobe is registered as 0 when req_write_i=0.
- SETUP (one cycle): psel_o=1, penable_o=0; go to ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1.
  - Stay while pready_i=0.
  - On pready_i=1: capture rsp_err_o=pslverr_i; capture rsp_rdata_o=prdata_i for reads, 0 for writes; go to RESP.
- RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o held stable.
  - On rsp_ready_i go to IDLE.
  - req_ready_o=0 in SETUP, ACCESS and RESP.
- Latency with zero-wait responder and rsp_ready_i=1:
  - Accept at cycle 0; SETUP cycle 1; ACCESS cycle 2; rsp_valid_o cycle 3; IDLE cycle 4.
  - Throughput is one transfer per 4 cycles.
- paddr_o, pwrite_o, pwdata_o, pstrb_o and pprot_o are driven from the request registers:
  - constant from SETUP through the end of ACCESS;
  - hold their last value in IDLE/RESP (no toggling while psel_o=0).
- psel_o and penable_o are registered outputs (glitch-free).
- prdata_i and pslverr_i are sampled only in the ACCESS cycle where pready_i=1.
- Only one outstanding transfer; no request pipelining.

Optional Feature:
- Macro: APB4_MST_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i=0.
  - When the count reaches TIMEOUT_CYCLES with pready_i still 0, terminate: go to RESP, rsp_err_o=1, rsp_rdata_o=0.
  - psel_o and penable_o deassert the next cycle.
  - If pready_i=1 in the limit cycle, the normal completion wins.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter; ACCESS waits on pready_i indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared define file apb4_mst_define.sv holds:
  - the FSM state encoding (2-bit: IDLE=0, SETUP=1, ACCESS=2, RESP=3);
  - the pprot default constant (3'b000).
- Registers use the common register primitives from register.sv.
- No sub-module: the FSM and the optional timeout counter stay in apb4_mst.

Test Plan:
- Write 0x5F3759DF to 0x10, strb 0xF, pready_i tied 1 → psel_o=1 in cycle 1, penable_o=1 in cycle 2, pwrite_o=1, pstrb_o=0xF; rsp_valid_o in cycle 3 with rsp_err_o=0, rsp_rdata_o=0.
- Read 0x0C, responder inserts 3 wait states then prdata_i=0xA5A50001 → ACCESS held 4 cycles with paddr_o=0x0C and pstrb_o=0 stable; rsp_rdata_o=0xA5A50001.
- Write with pslverr_i=1 on the ready cycle → rsp_err_o=1; next request still accepted normally.
- rsp_ready_i held 0 for 5 cycles with a second req_valid_i pending → rsp_valid_o held, req_ready_o=0, no psel_o; second transfer starts SETUP one cycle after the IDLE acceptance.
- rst_i asserted during ACCESS → next cycle psel_o=0, penable_o=0, rsp_valid_o=0, req_ready_o=1; no response emitted.
- Timeout, macro defined, TIMEOUT_CYCLES=4, pready_i stuck 0 → psel_o drops after 4 ACCESS cycles; rsp_err_o=1, rsp_rdata_o=0. Macro undefined → psel_o still high after 100 cycles.

Source files
------------

// File: rtl/apb4_mst_define.sv
// Shared definitions for the APB4 initiator.
//   state_e       : FSM state encoding (IDLE=0, SETUP=1, ACCESS=2, RESP=3)
//   PPROT_DEFAULT : pprot value held by the request register after reset
package apb4_mst_define;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } state_e;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/register.sv
// Common register primitive: synchronous active-high reset, load enable.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset, loads RESET_VAL
//   i_en   : load enable
//   i_d    : next value
//   o_q    : registered value
module register #(
  parameter int unsigned           WIDTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_q <= RESET_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/apb4_mst.sv
// APB4 initiator: turns one valid/ready request into a single SETUP/ACCESS
// transfer and returns the result on a valid/ready response channel.
// One transfer outstanding at a time.
//
// Optional feature macro: APB4_MST_TIMEOUT_EN
//   When defined, ACCESS is aborted with rsp_err_o=1 after TIMEOUT_CYCLES
//   cycles with pready_i low. When undefined, ACCESS waits indefinitely.
//
// Ports:
//   clk_i, rst_i                : clock, synchronous active-high reset
//   req_valid_i / req_ready_o   : request handshake
//   req_addr_i, req_write_i,
//   req_wdata_i, req_wstrb_i,
//   req_prot_i                  : request payload
//   rsp_valid_o / rsp_ready_i   : response handshake
//   rsp_rdata_o, rsp_err_o      : response payload (rdata is 0 for writes)
//   psel_o, penable_o, pwrite_o,
//   paddr_o, pwdata_o, pstrb_o,
//   pprot_o                     : APB4 requester outputs
//   prdata_i, pready_i,
//   pslverr_i                   : APB4 responder inputs
module apb4_mst
  import apb4_mst_define::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,  // 8, 16 or 32
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  output logic [2:0]              pprot_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  state_e r_state;
  state_e w_state_next;

  logic                  w_accept;
  logic                  w_timeout;
  logic                  w_rsp_load;
  logic [DATA_WIDTH-1:0] w_rsp_rdata;
  logic                  w_rsp_err;
  logic [STRB_WIDTH-1:0] w_strb;

  assign w_accept   = (r_state == StIdle) && req_valid_i;
  // Normal completion has priority over a timeout in the same cycle.
  assign w_rsp_load = (r_state == StAccess) && (pready_i || w_timeout);
  assign w_rsp_rdata = (pready_i && !pwrite_o) ? prdata_i : '0;
  assign w_rsp_err   = pready_i ? pslverr_i : 1'b1;
  assign w_strb      = req_write_i ? req_wstrb_i : '0;

  // FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (req_valid_i) w_state_next = StSetup;
      StSetup:  w_state_next = StAccess;
      StAccess: if (pready_i || w_timeout) w_state_next = StResp;
      StResp:   if (rsp_ready_i) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  assign req_ready_o = (r_state == StIdle);
  assign rsp_valid_o = (r_state == StResp);

  // psel/penable are decoded from the next state and registered, so they
  // change only on the clock edge together with the state.
  register #(.WIDTH(1)) u_psel (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_en  (1'b1),
    .i_d   ((w_state_next == StSetup) || (w_state_next == StAccess)),
    .o_q   (psel_o)
  );

  register #(.WIDTH(1)) u_penable (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_en  (1'b1),
    .i_d   (w_state_next == StAccess),
    .o_q   (penable_o)
  );

  // Request registers drive the APB bus directly; loaded only on accept so
  // they hold their value through IDLE and RESP.
  register #(.WIDTH(ADDR_WIDTH)) u_addr (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_en  (w_accept),
    .i_d   (req_addr_i),
    .o_q   (paddr_o)
  );

  register #(.WIDTH(1)) u_write (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_en  (w_accept),
    .i_d   (req_write_i),
    .o_q   (pwrite_o)
  );

  register #(.WIDTH(DATA_WIDTH)) u_wdata (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_en  (w_accept),
    .i_d   (req_wdata_i),
    .o_q   (pwdata_o)
  );

  register #(.WIDTH(STRB_WIDTH)) u_strb (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_en  (w_accept),
    .i_d   (w_strb),
    .o_q   (pstrb_o)
  );

  register #(.WIDTH(3), .RESET_VAL(PPROT_DEFAULT)) u_prot (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_en  (w_accept),
    .i_d   (req_prot_i),
    .o_q   (pprot_o)
  );

  // Response registers, loaded on the completing ACCESS cycle only.
  register #(.WIDTH(DATA_WIDTH)) u_rsp_rdata (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_en  (w_rsp_load),
    .i_d   (w_rsp_rdata),
    .o_q   (rsp_rdata_o)
  );

  register #(.WIDTH(1)) u_rsp_err (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_en  (w_rsp_load),
    .i_d   (w_rsp_err),
    .o_q   (rsp_err_o)
  );

`ifdef APB4_MST_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_WIDTH-1:0] r_to_cnt;
  logic [CNT_WIDTH-1:0] w_to_cnt_next;

  always_comb begin
    w_to_cnt_next = r_to_cnt;
    if (r_state == StSetup) begin
      w_to_cnt_next = '0;
    end else if ((r_state == StAccess) && !pready_i) begin
      w_to_cnt_next = r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= w_to_cnt_next;
    end
  end

  // This cycle's increment would reach the limit.
  assign w_timeout = (r_state == StAccess) && !pready_i &&
                     (r_to_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_apb4_mst.sv
module tb_apb4_mst;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic [2:0]    req_prot;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;

  int n_cmp = 0;
  int n_bad = 0;

  apb4_mst #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_write_i (req_write),
    .req_wdata_i (req_wdata),
    .req_wstrb_i (req_wstrb),
    .req_prot_i  (req_prot),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .paddr_o     (paddr),
    .pwdata_o    (pwdata),
    .pstrb_o     (pstrb),
    .pprot_o     (pprot),
    .prdata_i    (prdata),
    .pready_i    (pready),
    .pslverr_i   (pslverr)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [SW-1:0] s, input logic [2:0] p);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    req_prot  = p;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; req_prot = '0; rsp_ready = 1'b1; prdata = '0; pready = 1'b1;
    pslverr = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, req_ready} !== 6'b000001) begin
      $display("FAIL reset_ctrl: got %b want 000001",
               {psel, penable, pwrite, rsp_valid, rsp_err, req_ready});
      n_bad++;
    end
    n_cmp++;
    if ({paddr, pwdata, pstrb, pprot, rsp_rdata} !== '0) begin
      $display("FAIL reset_data: got addr=%h wdata=%h strb=%h prot=%h rdata=%h want all 0",
               paddr, pwdata, pstrb, pprot, rsp_rdata);
      n_bad++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    req(1'b1, 32'h10, 32'h5F3759DF, 4'hF, 3'b010);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      $display("FAIL wr_ready_idle: got %b want 1", req_ready); n_bad++;
    end
    tick();  // cycle 1: SETUP
    req_valid = 1'b0;
    n_cmp++;
    if ({psel, penable, pwrite, paddr, pwdata, pstrb, pprot, req_ready} !==
        {1'b1, 1'b0, 1'b1, 32'h10, 32'h5F3759DF, 4'hF, 3'b010, 1'b0}) begin
      $display("FAIL wr_setup: got sel=%b en=%b wr=%b addr=%h wdata=%h strb=%h prot=%h rdy=%b",
               psel, penable, pwrite, paddr, pwdata, pstrb, pprot, req_ready);
      n_bad++;
    end
    tick();  // cycle 2: ACCESS
    n_cmp++;
    if ({psel, penable, rsp_valid} !== 3'b110) begin
      $display("FAIL wr_access: got sel/en/rv=%b want 110", {psel, penable, rsp_valid});
      n_bad++;
    end
    tick();  // cycle 3: RESP
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata, psel, penable, req_ready} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL wr_resp: got rv=%b err=%b rdata=%h sel=%b en=%b rdy=%b",
               rsp_valid, rsp_err, rsp_rdata, psel, penable, req_ready);
      n_bad++;
    end
    tick();  // cycle 4: IDLE
    n_cmp++;
    if ({rsp_valid, req_ready, paddr} !== {1'b0, 1'b1, 32'h10}) begin
      $display("FAIL wr_idle: got rv=%b rdy=%b addr=%h want 0 1 00000010",
               rsp_valid, req_ready, paddr);
      n_bad++;
    end
  endtask

  task automatic test_read_wait();
    pready = 1'b0;
    prdata = 32'hDEADBEEF;
    req(1'b0, 32'h0C, 32'h0, 4'hF, 3'b000);
    tick();  // SETUP
    req_valid = 1'b0;
    n_cmp++;
    if ({psel, penable, pwrite, pstrb} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
      $display("FAIL rd_setup: got sel=%b en=%b wr=%b strb=%h", psel, penable, pwrite, pstrb);
      n_bad++;
    end
    tick();  // first ACCESS cycle
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({psel, penable, paddr, pstrb, rsp_valid} !== {1'b1, 1'b1, 32'h0C, 4'h0, 1'b0}) begin
        $display("FAIL rd_access_%0d: got sel=%b en=%b addr=%h strb=%h rv=%b",
                 i, psel, penable, paddr, pstrb, rsp_valid);
        n_bad++;
      end
      if (i == 3) begin
        pready = 1'b1;
        prdata = 32'hA5A50001;
      end
      tick();
    end
    prdata = 32'h0;  // response must not follow prdata after capture
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata, psel} !== {1'b1, 1'b0, 32'hA5A50001, 1'b0}) begin
      $display("FAIL rd_resp: got rv=%b err=%b rdata=%h sel=%b want 1 0 a5a50001 0",
               rsp_valid, rsp_err, rsp_rdata, psel);
      n_bad++;
    end
    tick();
  endtask

  task automatic test_slverr();
    pslverr = 1'b1;
    req(1'b1, 32'h20, 32'hCAFE0000, 4'h3, 3'b000);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      $display("FAIL err_resp: got rv=%b err=%b rdata=%h want 1 1 0",
               rsp_valid, rsp_err, rsp_rdata);
      n_bad++;
    end
    tick();
    pslverr = 1'b0;
    prdata  = 32'h12345678;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      $display("FAIL err_next_ready: got %b want 1", req_ready); n_bad++;
    end
    req(1'b0, 32'h24, 32'h0, 4'h0, 3'b000);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
      $display("FAIL err_next_resp: got rv=%b err=%b rdata=%h want 1 0 12345678",
               rsp_valid, rsp_err, rsp_rdata);
      n_bad++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    req(1'b1, 32'h30, 32'h11, 4'h1, 3'b000);
    tick();  // SETUP of first; second request now pending
    req(1'b0, 32'h34, 32'h0, 4'h0, 3'b001);
    n_cmp++;
    if ({req_ready, paddr, pwrite} !== {1'b0, 32'h30, 1'b1}) begin
      $display("FAIL b2b_hold_req: got rdy=%b addr=%h wr=%b want 0 00000030 1",
               req_ready, paddr, pwrite);
      n_bad++;
    end
    tick();  // ACCESS
    tick();  // RESP
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({rsp_valid, req_ready, psel} !== 3'b100) begin
        $display("FAIL b2b_stall_%0d: got rv/rdy/sel=%b want 100",
                 i, {rsp_valid, req_ready, psel});
        n_bad++;
      end
      tick();
    end
    rsp_ready = 1'b1;
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      $display("FAIL b2b_still_valid: got %b want 1", rsp_valid); n_bad++;
    end
    tick();  // IDLE: second request accepted here
    prdata = 32'h0BADF00D;
    n_cmp++;
    if ({req_ready, psel, rsp_valid} !== 3'b100) begin
      $display("FAIL b2b_idle: got rdy/sel/rv=%b want 100", {req_ready, psel, rsp_valid});
      n_bad++;
    end
    tick();  // SETUP of second
    req_valid = 1'b0;
    n_cmp++;
    if ({psel, penable, paddr, pwrite, pprot} !== {1'b1, 1'b0, 32'h34, 1'b0, 3'b001}) begin
      $display("FAIL b2b_setup2: got sel=%b en=%b addr=%h wr=%b prot=%h",
               psel, penable, paddr, pwrite, pprot);
      n_bad++;
    end
    tick();
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0BADF00D}) begin
      $display("FAIL b2b_resp2: got rv=%b rdata=%h want 1 0badf00d", rsp_valid, rsp_rdata);
      n_bad++;
    end
    tick();
  endtask

  task automatic test_reset_access();
    pready = 1'b0;
    req(1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
    tick();
    req_valid = 1'b0;
    tick();  // ACCESS
    n_cmp++;
    if ({psel, penable} !== 2'b11) begin
      $display("FAIL rst_pre_access: got sel/en=%b want 11", {psel, penable}); n_bad++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({psel, penable, rsp_valid, req_ready} !== 4'b0001) begin
      $display("FAIL rst_access: got sel/en/rv/rdy=%b want 0001",
               {psel, penable, rsp_valid, req_ready});
      n_bad++;
    end
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({rsp_valid, psel} !== 2'b00) begin
        $display("FAIL rst_no_rsp_%0d: got rv/sel=%b want 00", i, {rsp_valid, psel});
        n_bad++;
      end
    end
  endtask

  task automatic test_timeout();
    pready = 1'b0;
    prdata = 32'hFFFFFFFF;
    req(1'b0, 32'h50, 32'h0, 4'h0, 3'b000);
    tick();
    req_valid = 1'b0;
    tick();  // first ACCESS cycle
`ifdef APB4_MST_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({psel, penable} !== 2'b11) begin
        $display("FAIL to_access_%0d: got sel/en=%b want 11", i, {psel, penable});
        n_bad++;
      end
      tick();
    end
    n_cmp++;
    if ({psel, penable, rsp_valid, rsp_err, rsp_rdata} !== {4'b0011, 32'h0}) begin
      $display("FAIL to_resp: got sel=%b en=%b rv=%b err=%b rdata=%h want 0 0 1 1 0",
               psel, penable, rsp_valid, rsp_err, rsp_rdata);
      n_bad++;
    end
    tick();
    // pready in the limit cycle: normal completion wins
    req(1'b0, 32'h54, 32'h0, 4'h0, 3'b000);
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        pready = 1'b1;
        prdata = 32'h0000600D;
      end
      tick();
    end
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0000600D}) begin
      $display("FAIL to_limit_ready: got rv=%b err=%b rdata=%h want 1 0 0000600d",
               rsp_valid, rsp_err, rsp_rdata);
      n_bad++;
    end
    tick();
`else
    for (int i = 0; i < 100; i++) tick();
    n_cmp++;
    if ({psel, penable, rsp_valid} !== 3'b110) begin
      $display("FAIL no_timeout: got sel/en/rv=%b want 110", {psel, penable, rsp_valid});
      n_bad++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pready = 1'b1;
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_back_to_back();
    test_reset_access();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
